// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MADD_EN.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    nhi;
    logic [31:0]    nlo;
    logic           wr;

    logic [63:0]    sprod;
    logic [63:0]    uprod;
    logic [31:0]    abs_a;
    logic [31:0]    abs_b;
    logic [31:0]    dvs_s;
    logic [31:0]    dvs_u;
    logic [31:0]    q_s;
    logic [31:0]    r_s;
    logic [31:0]    q_u;
    logic [31:0]    r_u;
    logic [63:0]    res;
    logic           launch;
    logic           res_ok;
    logic [CW-1:0]  lat;

    always_comb begin
        sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        uprod = {32'd0, A} * {32'd0, B};
        // Signed divide on magnitudes: avoids the -2^31/-1 overflow corner and
        // gives truncation toward zero with remainder following the dividend.
        abs_a = A[31] ? (~A + 32'd1) : A;
        abs_b = B[31] ? (~B + 32'd1) : B;
        dvs_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
        dvs_u = (B == 32'd0) ? 32'd1 : B;
        q_s   = abs_a / dvs_s;
        r_s   = abs_a % dvs_s;
        q_u   = A / dvs_u;
        r_u   = A % dvs_u;

        res    = 64'd0;
        launch = 1'b0;
        res_ok = 1'b1;
        lat    = CW'(MULT_CYCLES);
        case (op)
            OP_MULT:  begin launch = 1'b1; res = sprod; end
            OP_MULTU: begin launch = 1'b1; res = uprod; end
            OP_DIV: begin
                launch = 1'b1;
                lat    = CW'(DIV_CYCLES);
                res_ok = (B != 32'd0);
                res    = {(A[31] ? (~r_s + 32'd1) : r_s),
                          ((A[31] ^ B[31]) ? (~q_s + 32'd1) : q_s)};
            end
            OP_DIVU: begin
                launch = 1'b1;
                lat    = CW'(DIV_CYCLES);
                res_ok = (B != 32'd0);
                res    = {r_u, q_u};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin launch = 1'b1; res = {HI, LO} + sprod; end
            OP_MADDU: begin launch = 1'b1; res = {HI, LO} + uprod; end
            OP_MSUB:  begin launch = 1'b1; res = {HI, LO} - sprod; end
            OP_MSUBU: begin launch = 1'b1; res = {HI, LO} - uprod; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            nhi   <= 32'd0;
            nlo   <= 32'd0;
            wr    <= 1'b0;
            busy  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (launch) begin
                            nhi   <= res[63:32];
                            nlo   <= res[31:0];
                            wr    <= res_ok;
                            cnt   <= lat;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else if (op == OP_MTHI) begin
                            HI <= A;
                        end else if (op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    // Any start seen here is dropped; the hazard unit owns that.
                    if (cnt <= CW'(1)) begin
                        if (wr) begin
                            HI <= nhi;
                            LO <= nlo;
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against an arithmetic model of HI/LO.
module tb_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .RESET(RESET), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Architectural effect of one op on the model's HI/LO, plus its busy length.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        longint x;
        longint y;
        logic [63:0] p;
        lat = 0;
        case (o)
            4'd1: begin
                x = longint'($signed(a)) * longint'($signed(b));
                {exp_hi, exp_lo} = x;
                lat = MC;
            end
            4'd2: begin
                {exp_hi, exp_lo} = 64'(a) * 64'(b);
                lat = MC;
            end
            4'd3: begin
                lat = DC;
                if (b != 32'd0) begin
                    x = longint'($signed(a));
                    y = longint'($signed(b));
                    exp_lo = 32'(x / y);
                    exp_hi = 32'(x % y);
                end
            end
            4'd4: begin
                lat = DC;
                if (b != 32'd0) begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            4'd5: exp_hi = a;
            4'd6: exp_lo = a;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (o == 4'd7 || o == 4'd9)
                    p = 64'(longint'($signed(a)) * longint'($signed(b)));
                else
                    p = 64'(a) * 64'(b);
                if (o <= 4'd8) {exp_hi, exp_lo} = {exp_hi, exp_lo} + p;
                else           {exp_hi, exp_lo} = {exp_hi, exp_lo} - p;
                lat = MC;
            end
`endif
            default: ;
        endcase
    endtask

    // Issue one op, count busy cycles while scrambling A/B, then check HI/LO.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        int lat;
        int n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(o, a, b, lat);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 1) chk("hold_during_run", {HI, LO}, {old_hi, old_lo});
            if (inject && n == 2) begin
                start = 1'b1; op = 4'd6;
            end else begin
                start = 1'b0; op = 4'd0;
            end
            A = $urandom;
            B = $urandom;
            @(negedge clk);
        end
        start = 1'b0; op = 4'd0;
        chk("busy_cycles", 64'(n), 64'(lat));
        chk("hilo", {HI, LO}, {exp_hi, exp_lo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'h8000_0000;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'd0;
            3: pick = 32'($urandom_range(0, 20));
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        RESET = 1'b0;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("multu_const", {HI, LO}, 64'h0000_0002_FFFF_FFFA);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);

        run_op(4'd5, 32'h11, 32'd0, 1'b0);
        run_op(4'd6, 32'h22, 32'd0, 1'b0);
        run_op(4'd4, 32'd5, 32'd0, 1'b0);
        chk("divu_zero_const", {HI, LO}, 64'h0000_0011_0000_0022);

        run_op(4'd5, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_const", 64'(HI), 64'h1234_5678);
        run_op(4'd1, 32'd9, 32'd9, 1'b1);
        chk("mtlo_ignored_const", 64'(LO), 64'd81);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        repeat (3) @(negedge clk);
        chk("busy_before_rst", 64'(busy), 64'd1);
        RESET = 1'b1;
        #1;
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_hilo", {HI, LO}, 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        RESET = 1'b0;
        run_op(4'd1, 32'd6, 32'd7, 1'b0);
        chk("mult_after_rst", 64'(LO), 64'd42);

        run_op(4'd5, 32'd0, 32'd0, 1'b0);
        run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        chk("maddu_const", {HI, LO}, 64'h0000_0001_0000_0000);
`else
        chk("maddu_off_const", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            run_op(o, pick(), pick(), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
